// File: rtl/regfile_access_ctrl_pkg.sv
// Shared encodings for the register-file access controller: ops, register
// indices, FSM states, the queued request record and the legality rule.
package regfile_ctrl_pkg;
    localparam int DEPTH = 2;

    typedef enum logic [1:0] {
        OP_WRITE       = 2'b00,
        OP_WRITE_CARRY = 2'b01,
        OP_SWAP        = 2'b10,
        OP_READ        = 2'b11
    } op_e;

    localparam logic [2:0] REG_ZERO   = 3'd0;
    localparam logic [2:0] REG_IMM    = 3'd1;
    localparam logic [2:0] REG_T1     = 3'd2;
    localparam logic [2:0] REG_T2     = 3'd3;
    localparam logic [2:0] REG_S1     = 3'd4;
    localparam logic [2:0] REG_S2     = 3'd5;
    localparam logic [2:0] REG_S3     = 3'd6;
    localparam logic [2:0] REG_BRANCH = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    typedef struct packed {
        op_e        op;
        logic [1:0] reg_a;
        logic [2:0] reg_b;
        logic [7:0] data;
    } req_t;

    // Requests that would clobber the hardwired zero register or the
    // carry/immediate register are dropped rather than issued.
    function automatic logic is_illegal(req_t r);
        case (r.op)
            OP_WRITE:       return r.reg_b == REG_ZERO;
            OP_WRITE_CARRY: return (r.reg_b == REG_ZERO) || (r.reg_b == REG_IMM);
            OP_SWAP:        return (r.reg_a == 2'd0) || (r.reg_b == REG_ZERO);
            default:        return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Request port, register-file control/readback and response strobes of the
// access controller, bundled with a controller (slave) and environment view.
interface regfile_access_ctrl_if;
    logic                   req_valid;
    logic                   req_ready;
    regfile_ctrl_pkg::op_e  req_op;
    logic [1:0]             req_reg_a;
    logic [2:0]             req_reg_b;
    logic [7:0]             req_data;

    logic                   write_ctrl;
    logic                   carry_out;
    logic                   swap_ctrl;
    logic [2:0]             write_reg;
    logic [7:0]             write_val;
    logic [1:0]             read_reg1;
    logic [2:0]             read_reg2;
    logic [7:0]             read_val1;
    logic [7:0]             read_val2;

    logic                   rsp_valid;
    logic [7:0]             rsp_data1;
    logic [7:0]             rsp_data2;
    logic                   err;

    modport slave (
        input  req_valid, req_op, req_reg_a, req_reg_b, req_data, read_val1, read_val2,
        output req_ready, write_ctrl, carry_out, swap_ctrl, write_reg, write_val,
               read_reg1, read_reg2, rsp_valid, rsp_data1, rsp_data2, err
    );

    modport master (
        output req_valid, req_op, req_reg_a, req_reg_b, req_data, read_val1, read_val2,
        input  req_ready, write_ctrl, carry_out, swap_ctrl, write_reg, write_val,
               read_reg1, read_reg2, rsp_valid, rsp_data1, rsp_data2, err
    );
endinterface

// File: rtl/regfile_access_ctrl_req_fifo.sv
// Two-entry request FIFO. full_n_o is a registered not-full flag, low in reset,
// so a push is never taken while full even if a pop happens on the same edge.
module req_fifo import regfile_ctrl_pkg::*; (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  req_t wdata_i,
    input  logic pop_i,
    output req_t rdata_o,
    output logic empty_o,
    output logic full_n_o
);
    localparam logic [1:0] FULL_CNT = 2'd2;

    req_t       mem_q [DEPTH];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q, count_d;
    logic       full_n_q;
    logic       do_push, do_pop;

    assign do_push = push_i && full_n_q;
    assign do_pop  = pop_i && (count_q != 2'd0);

    always_comb count_d = count_q + 2'(do_push) - 2'(do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            full_n_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q  <= count_d;
            full_n_q <= (count_d != FULL_CNT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o  = mem_q[rd_ptr_q];
    assign empty_o  = (count_q == 2'd0);
    assign full_n_o = full_n_q;
endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequences queued register-file requests onto the file's control inputs so
// each operation is held across one full cycle and lands on the file's negedge.
module regfile_access_ctrl import regfile_ctrl_pkg::*; (
    input  logic                  clk_i,
    input  logic                  rst_i,
    regfile_access_ctrl_if.slave  bus_if
);
    req_t       push_req, head;
    logic       fifo_empty, fifo_full_n, pop;
    state_e     state_q;
    logic       wr_q, carry_q, swap_q, rd_act_q, rsp_valid_q, err_q;
    logic [2:0] wreg_q, rreg2_q;
    logic [1:0] rreg1_q;
    logic [7:0] wval_q, rsp1_q, rsp2_q;

    assign push_req = '{op: bus_if.req_op, reg_a: bus_if.req_reg_a,
                        reg_b: bus_if.req_reg_b, data: bus_if.req_data};

    req_fifo u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (bus_if.req_valid),
        .wdata_i  (push_req),
        .pop_i    (pop),
        .rdata_o  (head),
        .empty_o  (fifo_empty),
        .full_n_o (fifo_full_n)
    );

    // SETTLE marks the swap cycle itself; nothing is popped at its closing
    // edge, giving the swapped values an idle cycle before the next access.
    assign pop = (state_q != ST_SETTLE) && !fifo_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            carry_q     <= 1'b0;
            swap_q      <= 1'b0;
            rd_act_q    <= 1'b0;
            wreg_q      <= 3'd0;
            wval_q      <= 8'd0;
            rreg1_q     <= 2'd0;
            rreg2_q     <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp1_q      <= 8'd0;
            rsp2_q      <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            wr_q        <= 1'b0;
            carry_q     <= 1'b0;
            swap_q      <= 1'b0;
            rd_act_q    <= 1'b0;
            wreg_q      <= 3'd0;
            wval_q      <= 8'd0;
            rreg1_q     <= 2'd0;
            rreg2_q     <= 3'd0;
            err_q       <= 1'b0;
            rsp_valid_q <= rd_act_q;
            if (rd_act_q) begin
                rsp1_q <= bus_if.read_val1;
                rsp2_q <= bus_if.read_val2;
            end
            if (pop) begin
                state_q <= ST_ISSUE;
                if (is_illegal(head)) begin
                    err_q <= 1'b1;
                end else begin
                    case (head.op)
                        OP_WRITE, OP_WRITE_CARRY: begin
                            wr_q    <= 1'b1;
                            carry_q <= (head.op == OP_WRITE_CARRY);
                            wreg_q  <= head.reg_b;
                            wval_q  <= head.data;
                        end
                        OP_SWAP: begin
                            swap_q  <= 1'b1;
                            rreg1_q <= head.reg_a;
                            rreg2_q <= head.reg_b;
                            state_q <= ST_SETTLE;
                        end
                        default: begin
                            rd_act_q <= 1'b1;
                            rreg1_q  <= head.reg_a;
                            rreg2_q  <= head.reg_b;
                        end
                    endcase
                end
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

    assign bus_if.req_ready  = fifo_full_n;
    assign bus_if.write_ctrl = wr_q;
    assign bus_if.carry_out  = carry_q;
    assign bus_if.swap_ctrl  = swap_q;
    assign bus_if.write_reg  = wreg_q;
    assign bus_if.write_val  = wval_q;
    assign bus_if.read_reg1  = rreg1_q;
    assign bus_if.read_reg2  = rreg2_q;
    assign bus_if.rsp_valid  = rsp_valid_q;
    assign bus_if.rsp_data1  = rsp1_q;
    assign bus_if.rsp_data2  = rsp2_q;
    assign bus_if.err        = err_q;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: register-file model, queue-based reference
// model compared every cycle, and directed sequences with literal results.
module tb_regfile_access_ctrl;
    import regfile_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_access_ctrl_if bus();
    regfile_access_ctrl dut (.clk_i(clk), .rst_i(rst), .bus_if(bus));

    int checks = 0;
    int errors = 0;

    // Register file: reg0 hardwired zero, writes/swaps at negedge.
    logic [7:0] rf [8] = '{default: 8'h00};
    assign bus.read_val1 = rf[{1'b0, bus.read_reg1}];
    assign bus.read_val2 = rf[bus.read_reg2];
    always @(negedge clk) begin
        if (bus.write_ctrl && bus.write_reg != 3'd0) rf[bus.write_reg] <= bus.write_val;
        if (bus.carry_out) rf[1] <= 8'h01;
        if (bus.swap_ctrl) begin
            if (bus.read_reg1 != 2'd0) rf[{1'b0, bus.read_reg1}] <= rf[bus.read_reg2];
            if (bus.read_reg2 != 3'd0) rf[bus.read_reg2] <= rf[{1'b0, bus.read_reg1}];
        end
    end

    // Reference model: queue of accepted requests, one issue per cycle,
    // a swap blocks the following slot, architectural register array.
    typedef struct { op_e op; logic [1:0] a; logic [2:0] b; logic [7:0] d; } mreq_t;
    mreq_t      mq[$];
    mreq_t      cur, h;
    bit         cur_v = 0, skip = 0, m_ready = 0, e_err = 0, e_rv = 0;
    logic [7:0] e_r1 = 8'h00, e_r2 = 8'h00;
    logic [7:0] arch [8] = '{default: 8'h00};

    function automatic bit bad(mreq_t r);
        if (r.op == OP_WRITE)       return r.b == 3'd0;
        if (r.op == OP_WRITE_CARRY) return r.b < 3'd2;
        if (r.op == OP_SWAP)        return r.a == 2'd0 || r.b == 3'd0;
        return 1'b0;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            cur_v = 0; skip = 0; m_ready = 0; e_err = 0; e_rv = 0; e_r1 = 8'h00; e_r2 = 8'h00;
        end else begin
            e_rv = cur_v && cur.op == OP_READ;
            if (e_rv) begin
                e_r1 = arch[{1'b0, cur.a}];
                e_r2 = arch[cur.b];
            end
            e_err = 0;
            if (skip) begin
                skip = 0; cur_v = 0;
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                if (bad(h)) begin e_err = 1; cur_v = 0; end
                else begin cur = h; cur_v = 1; skip = (h.op == OP_SWAP); end
            end else begin
                cur_v = 0;
            end
            if (bus.req_valid && m_ready)
                mq.push_back('{op: bus.req_op, a: bus.req_reg_a, b: bus.req_reg_b, d: bus.req_data});
            m_ready = mq.size() < 2;
        end
    end

    logic [7:0] tmp;
    initial forever begin
        @(negedge clk);
        if (!rst && cur_v) begin
            case (cur.op)
                OP_WRITE: arch[cur.b] = cur.d;
                OP_WRITE_CARRY: begin arch[cur.b] = cur.d; arch[1] = 8'h01; end
                OP_SWAP: begin
                    tmp = arch[{1'b0, cur.a}];
                    arch[{1'b0, cur.a}] = arch[cur.b];
                    arch[cur.b] = tmp;
                end
                default: ;
            endcase
        end
    end

    // Per-test observation counters and response log.
    int          n_wr, n_co, n_sw, n_err, saw_nr;
    logic [15:0] rsp_log[$];

    logic [37:0] act, expv;
    bit          w, r;
    initial forever begin
        @(negedge clk);
        w = cur_v && (cur.op == OP_WRITE || cur.op == OP_WRITE_CARRY);
        r = cur_v && (cur.op == OP_SWAP || cur.op == OP_READ);
        expv = {m_ready, w, w && cur.op == OP_WRITE_CARRY, cur_v && cur.op == OP_SWAP,
                w ? cur.b : 3'd0, w ? cur.d : 8'd0, r ? cur.a : 2'd0, r ? cur.b : 3'd0,
                e_rv, e_r1, e_r2, e_err};
        act  = {bus.req_ready, bus.write_ctrl, bus.carry_out, bus.swap_ctrl,
                bus.write_reg, bus.write_val, bus.read_reg1, bus.read_reg2,
                bus.rsp_valid, bus.rsp_data1, bus.rsp_data2, bus.err};
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL outputs t=%0t got=%h want=%h", $time, act, expv);
        end
        if (!rst) begin
            n_wr  += int'(bus.write_ctrl);
            n_co  += int'(bus.carry_out);
            n_sw  += int'(bus.swap_ctrl);
            n_err += int'(bus.err);
            if (!bus.req_ready) saw_nr++;
            if (bus.rsp_valid) rsp_log.push_back({bus.rsp_data1, bus.rsp_data2});
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic clr();
        n_wr = 0; n_co = 0; n_sw = 0; n_err = 0; saw_nr = 0;
        rsp_log.delete();
    endtask

    task automatic send(op_e op, logic [1:0] a, logic [2:0] b, logic [7:0] d);
        bit ok = 0;
        bus.req_valid = 1'b1;
        bus.req_op = op; bus.req_reg_a = a; bus.req_reg_b = b; bus.req_data = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            ok = bus.req_ready;
        end
        #1 bus.req_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout got=ready_low want=accepted");
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(string name, int idx, logic [15:0] want);
        chk(name, {16'h0, (idx < rsp_log.size()) ? rsp_log[idx] : 16'hDEAD}, {16'h0, want});
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = OP_WRITE;
        bus.req_reg_a = 2'd0; bus.req_reg_b = 3'd0; bus.req_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        chk("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);
        chk("rsp_data_reset", {16'h0, bus.rsp_data1, bus.rsp_data2}, 32'h0);

        // write t1 then read it back on both ports
        clr();
        send(OP_WRITE, 2'd0, REG_T1, 8'h5A);
        send(OP_READ, 2'd2, REG_T1, 8'h00);
        idle(6);
        chk("t1_wr_cycles", n_wr, 1);
        chk("t1_rsp_count", rsp_log.size(), 1);
        chk_rsp("t1_rsp", 0, 16'h5A5A);

        // write-with-carry sets imm
        clr();
        send(OP_WRITE_CARRY, 2'd0, REG_S1, 8'h80);
        send(OP_READ, 2'd1, REG_S1, 8'h00);
        idle(6);
        chk("t2_carry_cycles", n_co, 1);
        chk_rsp("t2_rsp", 0, 16'h0180);

        // swap then read
        clr();
        send(OP_WRITE, 2'd0, REG_T1, 8'h11);
        send(OP_WRITE, 2'd0, REG_S2, 8'h22);
        send(OP_SWAP, 2'd2, REG_S2, 8'h00);
        send(OP_READ, 2'd2, REG_S2, 8'h00);
        idle(6);
        chk("t3_swap_cycles", n_sw, 1);
        chk_rsp("t3_rsp", 0, 16'h2211);

        // illegal requests are dropped with an err strobe
        clr();
        send(OP_WRITE, 2'd0, REG_ZERO, 8'h33);
        send(OP_SWAP, 2'd0, REG_T2, 8'h00);
        send(OP_WRITE_CARRY, 2'd0, REG_IMM, 8'h77);
        send(OP_WRITE, 2'd0, REG_T2, 8'h44);
        send(OP_READ, 2'd3, REG_T2, 8'h00);
        idle(6);
        chk("t4_err_count", n_err, 3);
        chk("t4_swap_cycles", n_sw, 0);
        chk("t4_wr_cycles", n_wr, 1);
        chk_rsp("t4_rsp", 0, 16'h4444);

        // back-pressure behind a swap, order preserved
        clr();
        send(OP_SWAP, 2'd2, REG_S2, 8'h00);
        send(OP_WRITE, 2'd0, REG_S3, 8'hA1);
        send(OP_WRITE, 2'd0, REG_BRANCH, 8'hA2);
        send(OP_WRITE, 2'd0, REG_S3, 8'hA3);
        send(OP_READ, 2'd2, REG_S3, 8'h00);
        send(OP_READ, 2'd3, REG_BRANCH, 8'h00);
        idle(6);
        chk("t5_ready_dropped", {31'h0, saw_nr > 0}, 32'h1);
        chk("t5_wr_cycles", n_wr, 3);
        chk_rsp("t5_rsp0", 0, 16'h11A3);
        chk_rsp("t5_rsp1", 1, 16'h44A2);

        // reset in the middle of an issued write, before the file's negedge
        clr();
        send(OP_WRITE, 2'd0, REG_T2, 8'hFF);
        send(OP_WRITE, 2'd0, REG_S3, 8'h5C);
        #1;
        chk("t6_write_issued", {31'h0, bus.write_ctrl}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_outputs_in_reset",
            {bus.req_ready, bus.write_ctrl, bus.carry_out, bus.swap_ctrl, bus.write_reg,
             bus.read_reg1, bus.read_reg2, bus.rsp_valid, bus.err, bus.write_val, bus.rsp_data1},
            32'h0);
        idle(2);
        rst = 1'b0;
        clr();
        idle(4);
        chk("t6_t2_unchanged", {24'h0, rf[3]}, 32'h44);
        chk("t6_fifo_dropped", n_wr, 0);
        send(OP_READ, 2'd3, REG_S3, 8'h00);
        idle(5);
        chk_rsp("t6_rsp", 0, 16'h44A3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
